sdram_arbit: RTL and testbench



---
 rtl/sdram_arbit.sv | 175 +++++++++++++++++
 tb/tb_sdram_arbit.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbit.sv
// Command arbiter for the SDRAM controller: grants one of init/refresh/write/read
// at a time, pulses that stage's enable and muxes its command/address/data to the pins.
module sdram_arbit #(
    parameter int ADDR_W      = 13,
    parameter int BANK_W      = 2,
    parameter int DQ_W        = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              arb_clk,
    input  logic              arb_rst,
    input  logic              init_end,
    input  logic [3:0]        init_cmd,
    input  logic [BANK_W-1:0] init_bank,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic              ar_req,
    input  logic              ar_end,
    input  logic [3:0]        ar_cmd,
    input  logic [BANK_W-1:0] ar_bank,
    input  logic [ADDR_W-1:0] ar_addr,
    input  logic              wr_req,
    input  logic              wr_end,
    input  logic [3:0]        wr_cmd,
    input  logic [BANK_W-1:0] wr_bank,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DQ_W-1:0]   wr_dq,
    input  logic              wr_dq_oe,
    input  logic              rd_req,
    input  logic              rd_end,
    input  logic [3:0]        rd_cmd,
    input  logic [BANK_W-1:0] rd_bank,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              ar_en,
    output logic              wr_en,
    output logic              rd_en,
    output logic [3:0]        sdram_cmd,
    output logic [BANK_W-1:0] sdram_bank,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [DQ_W-1:0]   sdram_dq_out,
    output logic              sdram_dq_oe,
    output logic              err_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [3:0] LP_CMD_NOP = 4'b0111;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_AREF,
        ST_WRITE,
        ST_READ
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_last_wr;
    logic             r_ar_en;
    logic             r_wr_en;
    logic             r_rd_en;
    logic             r_err;
    logic             w_end_hit;
    logic             w_expire;
    logic             w_timeout;

    // Only the end pulse of the stage currently holding the grant counts.
    assign w_end_hit = ((r_state == ST_AREF)  && ar_end) ||
                       ((r_state == ST_WRITE) && wr_end) ||
                       ((r_state == ST_READ)  && rd_end);
    assign w_expire  = (r_cnt == LP_CNT_LAST);

    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        case (r_state)
            ST_INIT: begin
                if (init_end) begin
                    w_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                // Tie between write and read goes to whichever was not served last.
                if (ar_req) begin
                    w_next = ST_AREF;
                end else if (wr_req && (!rd_req || !r_last_wr)) begin
                    w_next = ST_WRITE;
                end else if (rd_req) begin
                    w_next = ST_READ;
                end
            end
            ST_AREF, ST_WRITE, ST_READ: begin
                if (w_end_hit) begin
                    w_next = ST_IDLE;
                end else if (w_expire) begin
                    w_next    = ST_IDLE;
                    w_timeout = 1'b1;
                end
            end
            default: begin
                w_next = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge arb_clk) begin
        if (arb_rst) begin
            r_state   <= ST_INIT;
            r_cnt     <= '0;
            r_last_wr <= 1'b0;
            r_ar_en   <= 1'b0;
            r_wr_en   <= 1'b0;
            r_rd_en   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ar_en <= (r_state == ST_IDLE) && (w_next == ST_AREF);
            r_wr_en <= (r_state == ST_IDLE) && (w_next == ST_WRITE);
            r_rd_en <= (r_state == ST_IDLE) && (w_next == ST_READ);
            r_err   <= w_timeout;
            if ((r_state == ST_IDLE) && (w_next == ST_WRITE)) begin
                r_last_wr <= 1'b1;
            end else if ((r_state == ST_IDLE) && (w_next == ST_READ)) begin
                r_last_wr <= 1'b0;
            end
            // Counter restarts at 0 whenever the granted state is entered or left.
            if ((r_state == ST_INIT) || (r_state == ST_IDLE) || (w_next != r_state)) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        sdram_cmd    = LP_CMD_NOP;
        sdram_bank   = '1;
        sdram_addr   = '1;
        sdram_dq_out = '0;
        sdram_dq_oe  = 1'b0;
        case (r_state)
            ST_INIT: begin
                sdram_cmd  = init_cmd;
                sdram_bank = init_bank;
                sdram_addr = init_addr;
            end
            ST_AREF: begin
                sdram_cmd  = ar_cmd;
                sdram_bank = ar_bank;
                sdram_addr = ar_addr;
            end
            ST_WRITE: begin
                sdram_cmd    = wr_cmd;
                sdram_bank   = wr_bank;
                sdram_addr   = wr_addr;
                sdram_dq_out = wr_dq;
                sdram_dq_oe  = wr_dq_oe;
            end
            ST_READ: begin
                sdram_cmd  = rd_cmd;
                sdram_bank = rd_bank;
                sdram_addr = rd_addr;
            end
            default: begin
                sdram_cmd = LP_CMD_NOP;
            end
        endcase
    end

    assign ar_en       = r_ar_en;
    assign wr_en       = r_wr_en;
    assign rd_en       = r_rd_en;
    assign err_timeout = r_err;

endmodule

// File: tb/tb_sdram_arbit.sv
// Bench for sdram_arbit: a table of directed cycles, hand-written multi-cycle
// sequences, then randomized traffic checked against a phase/age reference model.
module tb_sdram_arbit;

    localparam int ADDR_W = 13;
    localparam int BANK_W = 2;
    localparam int DQ_W   = 16;
    localparam int TMO    = 16;

    localparam int PH_INIT = 0;
    localparam int PH_IDLE = 1;
    localparam int PH_AR   = 2;
    localparam int PH_WR   = 3;
    localparam int PH_RD   = 4;

    logic              arb_clk = 1'b0;
    logic              arb_rst;
    logic              init_end;
    logic [3:0]        init_cmd;
    logic [BANK_W-1:0] init_bank;
    logic [ADDR_W-1:0] init_addr;
    logic              ar_req, ar_end;
    logic [3:0]        ar_cmd;
    logic [BANK_W-1:0] ar_bank;
    logic [ADDR_W-1:0] ar_addr;
    logic              wr_req, wr_end;
    logic [3:0]        wr_cmd;
    logic [BANK_W-1:0] wr_bank;
    logic [ADDR_W-1:0] wr_addr;
    logic [DQ_W-1:0]   wr_dq;
    logic              wr_dq_oe;
    logic              rd_req, rd_end;
    logic [3:0]        rd_cmd;
    logic [BANK_W-1:0] rd_bank;
    logic [ADDR_W-1:0] rd_addr;
    logic              ar_en, wr_en, rd_en;
    logic [3:0]        sdram_cmd;
    logic [BANK_W-1:0] sdram_bank;
    logic [ADDR_W-1:0] sdram_addr;
    logic [DQ_W-1:0]   sdram_dq_out;
    logic              sdram_dq_oe;
    logic              err_timeout;

    sdram_arbit #(
        .ADDR_W(ADDR_W), .BANK_W(BANK_W), .DQ_W(DQ_W), .TIMEOUT_CYC(TMO)
    ) dut (
        .arb_clk(arb_clk), .arb_rst(arb_rst), .init_end(init_end),
        .init_cmd(init_cmd), .init_bank(init_bank), .init_addr(init_addr),
        .ar_req(ar_req), .ar_end(ar_end), .ar_cmd(ar_cmd), .ar_bank(ar_bank), .ar_addr(ar_addr),
        .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_bank(wr_bank), .wr_addr(wr_addr),
        .wr_dq(wr_dq), .wr_dq_oe(wr_dq_oe),
        .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_bank(rd_bank), .rd_addr(rd_addr),
        .ar_en(ar_en), .wr_en(wr_en), .rd_en(rd_en),
        .sdram_cmd(sdram_cmd), .sdram_bank(sdram_bank), .sdram_addr(sdram_addr),
        .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe), .err_timeout(err_timeout)
    );

    always #5 arb_clk = ~arb_clk;

    typedef struct {
        bit         rst, initEnd, arReq, arEnd, wrReq, wrEnd, rdReq, rdEnd;
        bit         eAr, eWr, eRd;
        logic [3:0] eCmd;
    } vecT;

    vecT   tbl[$];
    int    checks = 0;
    int    errors = 0;
    int    mPhase = PH_INIT;
    int    mAge   = 0;
    bit    mLastWr = 1'b0;
    bit    eAr, eWr, eRd, eErr;
    string order;
    int    which, age, grants, cyc, errAt, errSeen, endDiv;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, want, $time);
        end
    endtask

    // Reference model: advance by one clock edge using the inputs presented now.
    task automatic modelStep();
        bit endHit;
        eAr = 0; eWr = 0; eRd = 0; eErr = 0;
        if (arb_rst) begin
            mPhase = PH_INIT; mAge = 0; mLastWr = 0;
            return;
        end
        case (mPhase)
            PH_INIT: if (init_end) mPhase = PH_IDLE;
            PH_IDLE: begin
                if (ar_req) begin
                    mPhase = PH_AR; mAge = 1; eAr = 1;
                end else if (wr_req && (!rd_req || !mLastWr)) begin
                    mPhase = PH_WR; mAge = 1; eWr = 1; mLastWr = 1;
                end else if (rd_req) begin
                    mPhase = PH_RD; mAge = 1; eRd = 1; mLastWr = 0;
                end
            end
            default: begin
                endHit = (mPhase == PH_AR && ar_end) || (mPhase == PH_WR && wr_end) ||
                         (mPhase == PH_RD && rd_end);
                if (endHit) mPhase = PH_IDLE;
                else if (mAge == TMO) begin
                    mPhase = PH_IDLE; eErr = 1;
                end else mAge++;
            end
        endcase
    endtask

    task automatic applyStimulus();
        modelStep();
        @(posedge arb_clk);
        #1;
    endtask

    task automatic checkAll();
        logic [3:0]        eCmd;
        logic [BANK_W-1:0] eBank;
        logic [ADDR_W-1:0] eAddr;
        logic [DQ_W-1:0]   eDq;
        logic              eOe;
        eCmd = 4'b0111; eBank = '1; eAddr = '1; eDq = '0; eOe = 1'b0;
        case (mPhase)
            PH_INIT: begin eCmd = init_cmd; eBank = init_bank; eAddr = init_addr; end
            PH_AR:   begin eCmd = ar_cmd;   eBank = ar_bank;   eAddr = ar_addr;   end
            PH_WR:   begin
                eCmd = wr_cmd; eBank = wr_bank; eAddr = wr_addr; eDq = wr_dq; eOe = wr_dq_oe;
            end
            PH_RD:   begin eCmd = rd_cmd;   eBank = rd_bank;   eAddr = rd_addr;   end
            default: eCmd = 4'b0111;
        endcase
        checkOutput("ar_en", 32'(ar_en), 32'(eAr));
        checkOutput("wr_en", 32'(wr_en), 32'(eWr));
        checkOutput("rd_en", 32'(rd_en), 32'(eRd));
        checkOutput("err_timeout", 32'(err_timeout), 32'(eErr));
        checkOutput("sdram_cmd", 32'(sdram_cmd), 32'(eCmd));
        checkOutput("sdram_bank", 32'(sdram_bank), 32'(eBank));
        checkOutput("sdram_addr", 32'(sdram_addr), 32'(eAddr));
        checkOutput("sdram_dq_out", 32'(sdram_dq_out), 32'(eDq));
        checkOutput("sdram_dq_oe", 32'(sdram_dq_oe), 32'(eOe));
    endtask

    task automatic quietInputs();
        arb_rst = 0; init_end = 1;
        ar_req = 0; ar_end = 0; wr_req = 0; wr_end = 0; rd_req = 0; rd_end = 0;
    endtask

    task automatic randomBuses();
        init_cmd = 4'($urandom); init_bank = BANK_W'($urandom); init_addr = ADDR_W'($urandom);
        ar_cmd   = 4'($urandom); ar_bank   = BANK_W'($urandom); ar_addr   = ADDR_W'($urandom);
        wr_cmd   = 4'($urandom); wr_bank   = BANK_W'($urandom); wr_addr   = ADDR_W'($urandom);
        rd_cmd   = 4'($urandom); rd_bank   = BANK_W'($urandom); rd_addr   = ADDR_W'($urandom);
        wr_dq    = DQ_W'($urandom); wr_dq_oe = 1'($urandom);
    endtask

    initial begin
        quietInputs();
        init_cmd = 4'b0010; init_bank = 2'd1; init_addr = 13'h0123;
        ar_cmd   = 4'b0001; ar_bank   = 2'd2; ar_addr   = 13'h0400;
        wr_cmd   = 4'b0100; wr_bank   = 2'd3; wr_addr   = 13'h1A5A;
        rd_cmd   = 4'b0101; rd_bank   = 2'd0; rd_addr   = 13'h05A5;
        wr_dq    = 16'hBEEF; wr_dq_oe = 1'b1;

        // rst initEnd arReq arEnd wrReq wrEnd rdReq rdEnd | eAr eWr eRd eCmd
        tbl.push_back('{1,0,0,0,1,0,0,0, 0,0,0,4'b0010});
        tbl.push_back('{0,0,0,0,1,0,0,0, 0,0,0,4'b0010});
        tbl.push_back('{0,1,0,0,1,0,0,0, 0,0,0,4'b0111});
        tbl.push_back('{0,1,1,0,1,0,1,0, 1,0,0,4'b0001});
        tbl.push_back('{0,1,1,0,1,0,1,0, 0,0,0,4'b0001});
        tbl.push_back('{0,1,0,1,1,0,1,0, 0,0,0,4'b0111});
        tbl.push_back('{0,1,0,0,1,0,1,0, 0,1,0,4'b0100});
        tbl.push_back('{0,1,0,0,1,0,1,1, 0,0,0,4'b0100});
        tbl.push_back('{0,1,0,0,1,1,1,0, 0,0,0,4'b0111});
        tbl.push_back('{0,1,0,0,1,0,1,0, 0,0,1,4'b0101});
        tbl.push_back('{0,1,0,0,1,0,1,0, 0,0,0,4'b0101});
        tbl.push_back('{1,1,0,0,1,0,1,0, 0,0,0,4'b0010});
        tbl.push_back('{0,1,0,0,1,0,1,0, 0,0,0,4'b0111});
        tbl.push_back('{0,1,0,0,1,0,1,0, 0,1,0,4'b0100});
        tbl.push_back('{0,1,0,0,0,1,0,0, 0,0,0,4'b0111});

        foreach (tbl[i]) begin
            arb_rst = tbl[i].rst; init_end = tbl[i].initEnd;
            ar_req = tbl[i].arReq; ar_end = tbl[i].arEnd;
            wr_req = tbl[i].wrReq; wr_end = tbl[i].wrEnd;
            rd_req = tbl[i].rdReq; rd_end = tbl[i].rdEnd;
            applyStimulus();
            checkOutput($sformatf("tbl%0d_ar_en", i), 32'(ar_en), 32'(tbl[i].eAr));
            checkOutput($sformatf("tbl%0d_wr_en", i), 32'(wr_en), 32'(tbl[i].eWr));
            checkOutput($sformatf("tbl%0d_rd_en", i), 32'(rd_en), 32'(tbl[i].eRd));
            checkOutput($sformatf("tbl%0d_cmd", i), 32'(sdram_cmd), 32'(tbl[i].eCmd));
        end

        // Held in INIT for 50 cycles with a write pending, then released.
        quietInputs();
        arb_rst = 1; applyStimulus(); checkAll();
        arb_rst = 0; init_end = 0; wr_req = 1;
        for (int c = 0; c < 50; c++) begin
            applyStimulus(); checkAll();
            checkOutput("hold_wr_en", 32'(wr_en), 32'd0);
            checkOutput("hold_cmd", 32'(sdram_cmd), 32'(init_cmd));
        end
        init_end = 1;
        applyStimulus(); checkAll();
        checkOutput("init_exit_cmd", 32'(sdram_cmd), 32'(4'b0111));
        applyStimulus(); checkAll();
        checkOutput("first_wr_en", 32'(wr_en), 32'd1);
        wr_req = 0; wr_end = 1;
        applyStimulus(); checkAll();
        wr_end = 0;

        // Write and read both pending: 10-cycle transactions must alternate W,R,...
        arb_rst = 1; applyStimulus(); checkAll();
        arb_rst = 0; wr_req = 1; rd_req = 1;
        order = ""; which = 0; age = 0; grants = 0;
        for (int c = 0; c < 140; c++) begin
            wr_end = (which == 1 && age == 10);
            rd_end = (which == 2 && age == 10);
            applyStimulus(); checkAll();
            if (wr_end || rd_end) which = 0;
            if (wr_en) begin
                order = {order, "W"}; which = 1; age = 1; grants++;
            end else if (rd_en) begin
                order = {order, "R"}; which = 2; age = 1; grants++;
            end else if (which != 0) begin
                age++;
            end
            if (grants >= 8) begin wr_req = 0; rd_req = 0; end
        end
        wr_end = 0; rd_end = 0;
        checks++;
        if (order != "WRWRWRWR") begin
            errors++;
            $display("[TB] FAIL grant_order: got %s, expected WRWRWRWR", order);
        end

        // Write that never ends: watchdog fires on the first IDLE cycle after 16 in WRITE.
        for (int pass = 0; pass < 2; pass++) begin
            quietInputs(); wr_req = 1;
            cyc = 0; errAt = 0; errSeen = 0;
            for (int c = 0; c < 40; c++) begin
                wr_end = (pass == 1 && cyc == 16);
                applyStimulus(); checkAll();
                wr_req = 0;
                if (wr_en) cyc = 1;
                else if (cyc != 0) cyc++;
                if (err_timeout) begin errSeen++; if (errAt == 0) errAt = cyc; end
                if (cyc == 17) checkOutput($sformatf("wd%0d_idle_cmd", pass), 32'(sdram_cmd), 32'(4'b0111));
            end
            if (pass == 0) begin
                checkOutput("wd_expiry_cycle", 32'(errAt), 32'd17);
                checkOutput("wd_pulse_count", 32'(errSeen), 32'd1);
            end else begin
                checkOutput("wd_end_wins", 32'(errSeen), 32'd0);
            end
        end

        // Randomized traffic against the reference model.
        quietInputs();
        endDiv = 4;
        for (int c = 0; c < 4000; c++) begin
            if (c % 200 == 0) endDiv = ($urandom_range(0, 1) == 0) ? 4 : 40;
            randomBuses();
            arb_rst  = ($urandom_range(0, 499) == 0);
            init_end = ($urandom_range(0, 3) != 0);
            ar_req   = ($urandom_range(0, 7) == 0);
            wr_req   = 1'($urandom);
            rd_req   = 1'($urandom);
            ar_end   = ($urandom_range(0, endDiv - 1) == 0);
            wr_end   = ($urandom_range(0, endDiv - 1) == 0);
            rd_end   = ($urandom_range(0, endDiv - 1) == 0);
            applyStimulus(); checkAll();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
